sky130_fd_io__amux_bbm_ctrl: RTL and testbench

Core-side digital controller that drives the switch enables connecting a pad to analog mux buses AMUXBUS_A and AMUXBUS_B. It accepts connect/isolate requests over a valid/ready handshake and sequences them break-before-make, so the pad is never shorted across both buses. Each new connection gets a fixed settle interval before it is reported as usable. The controller sits in the always-on core domain next to the IO ring and feeds the level-shifted switch enables of the pad cells.

---
 rtl/sky130_fd_io__amux_pkg.sv | 25 ++
 rtl/sky130_fd_io__amux_dwell_cnt.sv | 29 ++
 rtl/sky130_fd_io__amux_bbm_ctrl.sv | 122 ++++++++++++
 tb/tb_sky130_fd_io__amux_bbm_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sky130_fd_io__amux_pkg.sv
// Shared types for the AMUX break-before-make controller: FSM states,
// bus-select encodings and the dwell-counter width helper.
package sky130_fd_io__amux_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DWELL  = 2'b01,
      SETTLE = 2'b10
   } state_t;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_NONE = 2'b00;
   localparam sel_t SEL_A    = 2'b01;
   localparam sel_t SEL_B    = 2'b10;
   localparam sel_t SEL_RSVD = 2'b11;

   // Smallest width that holds the larger of the two interval counts.
   function automatic int cnt_width(input int bbm, input int settle);
      int longest;
      longest = (bbm > settle) ? bbm : settle;
      return (longest < 1) ? 1 : $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/sky130_fd_io__amux_dwell_cnt.sv
// Loadable down-counter shared by the DWELL and SETTLE intervals; it
// saturates at zero instead of wrapping.
module sky130_fd_io__amux_dwell_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   // NOTE: non-blocking assignments for every flop so all state samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sky130_fd_io__amux_bbm_ctrl.sv
// Break-before-make sequencer for the pad-to-AMUXBUS switch enables.
// Define SKY130_FD_IO_AMUX_BBM_ABORT_EN to allow retargeting during SETTLE.
module sky130_fd_io__amux_bbm_ctrl
   import sky130_fd_io__amux_pkg::*;
#(
   parameter int BBM_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic [1:0] REQ_SEL,
   input  logic       ERR_CLR,
   output logic       AMUX_A_EN,
   output logic       AMUX_B_EN,
   output logic [1:0] CUR_SEL,
   output logic       BUSY,
   output logic       SETTLED,
   output logic       ERR
);

   localparam int        CW          = cnt_width(BBM_CYCLES, SETTLE_CYCLES);
   localparam logic [CW-1:0] BBM_LOAD    = CW'(BBM_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

   state_t          state;
   logic            accept;
   logic            change;
   logic            set_err;
   sel_t            target;
   logic            cnt_load;
   logic [CW-1:0]   cnt_load_val;
   logic            cnt_dec;
   logic            cnt_zero;

`ifdef SKY130_FD_IO_AMUX_BBM_ABORT_EN
   assign REQ_READY = (state == IDLE) || (state == SETTLE);
`else
   assign REQ_READY = (state == IDLE);
`endif

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      accept       = REQ_VALID && REQ_READY;
      set_err      = accept && (REQ_SEL == SEL_RSVD);
      target       = (REQ_SEL == SEL_RSVD) ? SEL_NONE : REQ_SEL;
      change       = accept && (target != CUR_SEL);
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      if (change) begin
         cnt_load     = 1'b1;
         cnt_load_val = BBM_LOAD;
      end else if ((state == DWELL) && cnt_zero && (CUR_SEL != SEL_NONE)) begin
         cnt_load     = 1'b1;
         cnt_load_val = SETTLE_LOAD;
      end else if ((state != IDLE) && !cnt_zero) begin
         cnt_dec = 1'b1;
      end
   end

   sky130_fd_io__amux_dwell_cnt #(
      .WIDTH (CW)
   ) u_dwell_cnt (
      .clk      (CLK),
      .rst      (RST),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // The async reset opens both switches immediately, without waiting for CLK.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         AMUX_A_EN <= 1'b0;
         AMUX_B_EN <= 1'b0;
         CUR_SEL   <= SEL_NONE;
         BUSY      <= 1'b0;
         SETTLED   <= 1'b1;
         ERR       <= 1'b0;
      end else begin
         ERR <= set_err || (ERR && !ERR_CLR);
         if (change) begin
            state     <= DWELL;
            AMUX_A_EN <= 1'b0;
            AMUX_B_EN <= 1'b0;
            CUR_SEL   <= target;
            BUSY      <= 1'b1;
            SETTLED   <= 1'b0;
         end else begin
            case (state)
               DWELL: begin
                  if (cnt_zero) begin
                     if (CUR_SEL == SEL_NONE) begin
                        state   <= IDLE;
                        BUSY    <= 1'b0;
                        SETTLED <= 1'b1;
                     end else begin
                        state     <= SETTLE;
                        AMUX_A_EN <= (CUR_SEL == SEL_A);
                        AMUX_B_EN <= (CUR_SEL == SEL_B);
                     end
                  end
               end
               SETTLE: begin
                  if (cnt_zero) begin
                     state   <= IDLE;
                     BUSY    <= 1'b0;
                     SETTLED <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sky130_fd_io__amux_bbm_ctrl.sv
// Self-checking bench: timeline reference model plus vector table, hand-written
// corner sequences and randomized traffic.
module tb_sky130_fd_io__amux_bbm_ctrl;

   localparam int BBM = 4;
   localparam int SET = 8;

   logic       CLK = 1'b0;
   logic       RST;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic [1:0] REQ_SEL;
   logic       ERR_CLR;
   logic       AMUX_A_EN;
   logic       AMUX_B_EN;
   logic [1:0] CUR_SEL;
   logic       BUSY;
   logic       SETTLED;
   logic       ERR;

   int checks   = 0;
   int failures = 0;

   sky130_fd_io__amux_bbm_ctrl #(
      .BBM_CYCLES    (BBM),
      .SETTLE_CYCLES (SET)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_SEL   (REQ_SEL),
      .ERR_CLR   (ERR_CLR),
      .AMUX_A_EN (AMUX_A_EN),
      .AMUX_B_EN (AMUX_B_EN),
      .CUR_SEL   (CUR_SEL),
      .BUSY      (BUSY),
      .SETTLED   (SETTLED),
      .ERR       (ERR)
   );

   always #5 CLK = ~CLK;

   // Reference model: remembers the target and the edge at which it was
   // accepted; every output follows from the elapsed edge count.
   int   m_cur;
   int   m_k;
   int   m_cyc;
   logic m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cur = 0;
      m_k   = -1000;
      m_cyc = 0;
      m_err = 1'b0;
   endtask

   function automatic int m_el();
      return m_cyc - m_k;
   endfunction

   function automatic logic m_settled();
      return m_el() >= (BBM + ((m_cur == 0) ? 0 : SET));
   endfunction

   function automatic logic m_ready();
`ifdef SKY130_FD_IO_AMUX_BBM_ABORT_EN
      return m_settled() || (m_el() >= BBM);
`else
      return m_settled();
`endif
   endfunction

   task automatic step();
      logic       acc;
      logic [1:0] tgt;
      logic       err_nxt;
      check("req_ready", REQ_READY, m_ready());
      acc     = REQ_VALID && m_ready();
      tgt     = (REQ_SEL == 2'b11) ? 2'b00 : REQ_SEL;
      err_nxt = (acc && (REQ_SEL == 2'b11)) || (m_err && !ERR_CLR);
      @(posedge CLK);
      m_cyc++;
      m_err = err_nxt;
      if (acc && (int'(tgt) != m_cur)) begin
         m_cur = int'(tgt);
         m_k   = m_cyc;
      end
      #1;
      check("a_en", AMUX_A_EN, (m_cur == 1) && (m_el() >= BBM));
      check("b_en", AMUX_B_EN, (m_cur == 2) && (m_el() >= BBM));
      check("cur_sel", CUR_SEL, m_cur);
      check("busy", BUSY, !m_settled());
      check("settled", SETTLED, m_settled());
      check("err", ERR, m_err);
      check("no_overlap", AMUX_A_EN && AMUX_B_EN, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_a_en"}, AMUX_A_EN, 1'b0);
      check({tag, "_b_en"}, AMUX_B_EN, 1'b0);
      check({tag, "_cur_sel"}, CUR_SEL, 2'b00);
      check({tag, "_ready"}, REQ_READY, 1'b1);
      check({tag, "_busy"}, BUSY, 1'b0);
      check({tag, "_settled"}, SETTLED, 1'b1);
      check({tag, "_err"}, ERR, 1'b0);
   endtask

   // Issues one change request and measures the break/make/settle timing.
   task automatic run_change(input logic [1:0] sel, input int exp_rise, input int exp_settle);
      int n;
      int low;
      int rise;
      logic tgt_en;
      REQ_VALID = 1'b1;
      REQ_SEL   = sel;
      step();
      REQ_VALID = 1'b0;
      check("chg_break_at_accept", AMUX_A_EN || AMUX_B_EN, 1'b0);
      low  = 1;
      rise = -1;
      n    = 0;
      while (!SETTLED && (n < 40)) begin
         step();
         n++;
         tgt_en = (sel == 2'b01) ? AMUX_A_EN : AMUX_B_EN;
         if (rise < 0) begin
            if (tgt_en) rise = n;
            else if (!AMUX_A_EN && !AMUX_B_EN) low++;
         end
      end
      check("chg_settle_lat", n, exp_settle);
      if (sel != 2'b00) begin
         check("chg_rise_lat", rise, exp_rise);
         check("chg_both_low", low, BBM);
      end
   endtask

   typedef struct {
      logic [1:0] sel;
      logic       clr;
      int         exp_settle;
      logic [1:0] exp_cur;
      logic       exp_err;
      logic       exp_a;
      logic       exp_b;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{2'b01, 1'b0, BBM + SET, 2'b01, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{2'b01, 1'b0, 0,         2'b01, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{2'b10, 1'b0, BBM + SET, 2'b10, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{2'b11, 1'b0, BBM,       2'b00, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{2'b11, 1'b1, 0,         2'b00, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{2'b00, 1'b1, 0,         2'b00, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{2'b10, 1'b0, BBM + SET, 2'b10, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{2'b00, 1'b0, BBM,       2'b00, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{2'b11, 1'b0, 0,         2'b00, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{2'b00, 1'b1, 0,         2'b00, 1'b0, 1'b0, 1'b0};

      RST       = 1'b1;
      REQ_VALID = 1'b0;
      REQ_SEL   = 2'b00;
      ERR_CLR   = 1'b0;
      model_reset();
      #12;
      check_reset_values("reset");
      RST = 1'b0;

      for (int i = 0; i < 10; i++) begin
         REQ_VALID = 1'b1;
         REQ_SEL   = vecs[i].sel;
         ERR_CLR   = vecs[i].clr;
         step();
         REQ_VALID = 1'b0;
         ERR_CLR   = 1'b0;
         n = 0;
         while (!SETTLED && (n < 40)) begin
            step();
            n++;
         end
         check("vec_settle_lat", n, vecs[i].exp_settle);
         check("vec_cur_sel", CUR_SEL, vecs[i].exp_cur);
         check("vec_err", ERR, vecs[i].exp_err);
         check("vec_a_en", AMUX_A_EN, vecs[i].exp_a);
         check("vec_b_en", AMUX_B_EN, vecs[i].exp_b);
      end

      // Isolate to A, then A to B: break at accept, BBM low cycles, make, settle.
      run_change(2'b01, BBM, BBM + SET);
      run_change(2'b10, BBM, BBM + SET);
      check("a_to_b_cur", CUR_SEL, 2'b10);

      // Async reset in the middle of the SETTLE interval for B.
      run_change(2'b00, 0, BBM);
      REQ_VALID = 1'b1;
      REQ_SEL   = 2'b10;
      step();
      REQ_VALID = 1'b0;
      for (int i = 0; i < BBM + 3; i++) step();
      check("rst_pre_b_en", AMUX_B_EN, 1'b1);
      #1;
      RST = 1'b1;
      #1;
      check_reset_values("async_rst");
      @(posedge CLK);
      #1;
      check_reset_values("held_rst");
      RST = 1'b0;
      model_reset();

`ifdef SKY130_FD_IO_AMUX_BBM_ABORT_EN
      // Retarget to B on the third SETTLE edge of A.
      REQ_VALID = 1'b1;
      REQ_SEL   = 2'b01;
      step();
      REQ_VALID = 1'b0;
      for (int i = 0; i < BBM + 2; i++) step();
      check("abort_a_up", AMUX_A_EN, 1'b1);
      REQ_VALID = 1'b1;
      REQ_SEL   = 2'b10;
      step();
      REQ_VALID = 1'b0;
      check("abort_a_drop", AMUX_A_EN, 1'b0);
      n = 0;
      while (!AMUX_B_EN && (n < 40)) begin
         step();
         n++;
      end
      check("abort_b_rise", n, BBM);
`else
      // A request for B held during A's sequence waits until A has settled.
      REQ_VALID = 1'b1;
      REQ_SEL   = 2'b01;
      step();
      REQ_SEL = 2'b10;
      n = 0;
      while (!SETTLED && (n < 40)) begin
         step();
         n++;
      end
      check("noabort_wait", n, BBM + SET);
      check("noabort_a_settled", AMUX_A_EN, 1'b1);
      check("noabort_ready", REQ_READY, 1'b1);
      step();
      REQ_VALID = 1'b0;
      check("noabort_b_accepted", CUR_SEL, 2'b10);
`endif
      n = 0;
      while (!SETTLED && (n < 40)) begin
         step();
         n++;
      end

      // Randomized traffic against the timeline model.
      for (int i = 0; i < 400; i++) begin
         REQ_VALID = ($urandom_range(0, 3) == 0);
         REQ_SEL   = 2'($urandom_range(0, 3));
         ERR_CLR   = ($urandom_range(0, 7) == 0);
         step();
      end
      REQ_VALID = 1'b0;
      ERR_CLR   = 1'b0;
      for (int i = 0; i < BBM + SET + 2; i++) step();
      check("final_settled", SETTLED, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
